// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide single-ported RAM between the IF and LS
// ports of the core. Each 32-bit access becomes four little-endian byte
// transfers. LS has fixed priority over IF, and a grant is only taken in IDLE.
// All RAM-side outputs and the done pulses are registered. They are computed
// from the next state, so they line up with the state they belong to.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [3:0]        ls_bsel,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_done,
  output logic              stall_req,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_TAIL = 3'd2,
    ST_WR      = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Select byte lane idx of a word (lane i = bits [8i+7:8i]).
  function automatic logic [7:0] byte_lane(input logic [DATA_W-1:0] word,
                                           input logic [1:0]        idx);
    logic [7:0] lane_v;
    case (idx)
      2'd0:    lane_v = word[7:0];
      2'd1:    lane_v = word[15:8];
      2'd2:    lane_v = word[23:16];
      2'd3:    lane_v = word[31:24];
      default: lane_v = 8'h00;
    endcase
    return lane_v;
  endfunction

  // Word-align a byte address. The low two bits never reach the RAM.
  function automatic logic [ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

  // Sequencer state and latched transaction context
  state_t            state_r,   state_s;
  logic [1:0]        cnt_r,     cnt_s;
  logic [ADDR_W-1:0] base_r,    base_s;
  logic              own_ls_r,  own_ls_s;
  logic [DATA_W-1:0] wdata_r,   wdata_s;
  logic [3:0]        bsel_r,    bsel_s;
  // Lanes 0..2 of a read in progress; lane 3 arrives in RD_TAIL
  logic [23:0]       rbuf_r,    rbuf_s;

  // Registered outputs
  logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0] ls_rdata_r, ls_rdata_s;
  logic              if_done_r,  if_done_s;
  logic              ls_done_r,  ls_done_s;
  logic              mem_ce_r,   mem_ce_s;
  logic              mem_we_r,   mem_we_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [7:0]        mem_din_r,  mem_din_s;

  // Next-state, context capture and next-cycle RAM/done outputs
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    base_s     = base_r;
    own_ls_s   = own_ls_r;
    wdata_s    = wdata_r;
    bsel_s     = bsel_r;
    rbuf_s     = rbuf_r;
    if_rdata_s = if_rdata_r;
    ls_rdata_s = ls_rdata_r;
    mem_ce_s   = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = {ADDR_W{1'b0}};
    mem_din_s  = 8'h00;
    if_done_s  = 1'b0;
    ls_done_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        cnt_s = 2'd0;
        if (ls_req) begin
          // LS wins any tie; the IF request keeps waiting for the next IDLE
          own_ls_s = 1'b1;
          base_s   = word_base(ls_addr);
          wdata_s  = ls_wdata;
          bsel_s   = ls_bsel;
          state_s  = ls_we ? ST_WR : ST_RD;
        end else if (if_req) begin
          own_ls_s = 1'b0;
          base_s   = word_base(if_addr);
          bsel_s   = 4'b0000;
          state_s  = ST_RD;
        end else begin
          state_s  = ST_IDLE;
        end
      end

      ST_RD: begin
        // The RAM returns a byte one cycle after it was addressed.
        case (cnt_r)
          2'd1:    rbuf_s[7:0]   = mem_dout;
          2'd2:    rbuf_s[15:8]  = mem_dout;
          2'd3:    rbuf_s[23:16] = mem_dout;
          default: rbuf_s        = rbuf_r;
        endcase
        if (cnt_r == 2'd3) begin
          cnt_s   = 2'd0;
          state_s = ST_RD_TAIL;
        end else begin
          cnt_s   = cnt_r + 2'd1;
          state_s = ST_RD;
        end
      end

      ST_RD_TAIL: begin
        // The last byte is here. The full word goes to the owner's register in one step.
        if (own_ls_r) begin
          ls_rdata_s = {mem_dout, rbuf_r};
        end else begin
          if_rdata_s = {mem_dout, rbuf_r};
        end
        state_s = ST_DONE;
      end

      ST_WR: begin
        if (cnt_r == 2'd3) begin
          cnt_s   = 2'd0;
          state_s = ST_DONE;
        end else begin
          cnt_s   = cnt_r + 2'd1;
          state_s = ST_WR;
        end
      end

      ST_DONE: begin
        // Requests are not resampled here. This forces one IDLE cycle between transactions.
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
        cnt_s   = 2'd0;
      end
    endcase

    // RAM drive for the cycle the next state describes
    if ((state_s == ST_RD) || (state_s == ST_WR)) begin
      mem_ce_s   = 1'b1;
      mem_addr_s = base_s + {{(ADDR_W-2){1'b0}}, cnt_s};
      if (state_s == ST_WR) begin
        mem_we_s  = bsel_s[cnt_s];
        mem_din_s = byte_lane(wdata_s, cnt_s);
      end else begin
        mem_we_s  = 1'b0;
        mem_din_s = 8'h00;
      end
    end else begin
      mem_ce_s   = 1'b0;
      mem_addr_s = {ADDR_W{1'b0}};
    end

    // One-cycle completion pulse to whichever port owns the transaction
    if (state_s == ST_DONE) begin
      if_done_s = ~own_ls_s;
      ls_done_s = own_ls_s;
    end else begin
      if_done_s = 1'b0;
      ls_done_s = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 2'd0;
      base_r     <= {ADDR_W{1'b0}};
      own_ls_r   <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
      bsel_r     <= 4'b0000;
      rbuf_r     <= 24'h000000;
      if_rdata_r <= {DATA_W{1'b0}};
      ls_rdata_r <= {DATA_W{1'b0}};
      if_done_r  <= 1'b0;
      ls_done_r  <= 1'b0;
      mem_ce_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_din_r  <= 8'h00;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      base_r     <= base_s;
      own_ls_r   <= own_ls_s;
      wdata_r    <= wdata_s;
      bsel_r     <= bsel_s;
      rbuf_r     <= rbuf_s;
      if_rdata_r <= if_rdata_s;
      ls_rdata_r <= ls_rdata_s;
      if_done_r  <= if_done_s;
      ls_done_r  <= ls_done_s;
      mem_ce_r   <= mem_ce_s;
      mem_we_r   <= mem_we_s;
      mem_addr_r <= mem_addr_s;
      mem_din_r  <= mem_din_s;
    end
  end

  assign if_rdata = if_rdata_r;
  assign ls_rdata = ls_rdata_r;
  assign if_done  = if_done_r;
  assign ls_done  = ls_done_r;
  assign mem_ce   = mem_ce_r;
  assign mem_we   = mem_we_r;
  assign mem_addr = mem_addr_r;
  assign mem_din  = mem_din_r;

  // The pipeline freezes while any request is still waiting for its done pulse.
  assign stall_req = (if_req & ~if_done_r) | (ls_req & ~ls_done_r);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It checks a table of directed transactions,
// hand-written multi-cycle sequences, and randomized traffic. Results are
// compared against a byte-array memory model kept in the bench.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [3:0]  ls_bsel;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_done;
  logic        stall_req;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  int n_checks = 0;
  int n_errors = 0;

  logic       ram_init;
  logic [7:0] ram     [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic [31:0] exp_if_rd;
  logic [31:0] exp_ls_rd;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_bsel(ls_bsel),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .stall_req(stall_req),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte RAM: a read byte appears one cycle after the read request; writes are synchronous
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[256] <= 8'h11;
      ram[257] <= 8'h22;
      ram[258] <= 8'h33;
      ram[259] <= 8'h44;
      mem_dout <= 8'h00;
    end else if (mem_ce && mem_we) begin
      ram[mem_addr[9:0]] <= mem_din;
    end else if (mem_ce) begin
      mem_dout <= ram[mem_addr[9:0]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word read from the reference memory, little-endian
  function automatic logic [31:0] model_read(input logic [31:0] addr);
    logic [9:0] b;
    b = {addr[9:2], 2'b00};
    return {ref_mem[b + 10'd3], ref_mem[b + 10'd2], ref_mem[b + 10'd1], ref_mem[b]};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [3:0] bsel,
                             input logic [31:0] wdata);
    logic [9:0] b;
    b = {addr[9:2], 2'b00};
    for (int i = 0; i < 4; i++)
      if (bsel[i]) ref_mem[b + 10'(i)] = wdata[8*i +: 8];
  endtask

  // One transaction from an IDLE cycle: returns the completion cycle, write strobes, and a protocol flag
  task automatic do_txn(input logic is_ls, input logic we, input logic [31:0] addr,
                        input logic [3:0] bsel, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat, output int nwe,
                        output logic seq_ok);
    logic [31:0] base;
    logic        seen;
    logic        dn;
    base = {addr[31:2], 2'b00};
    @(negedge clk);
    if (is_ls) begin
      ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_bsel = bsel; ls_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1; nwe = 0; seq_ok = 1'b1; seen = 1'b0; rdata = 32'h0;
    #1;
    if (!stall_req) seq_ok = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(posedge clk); #1;
      if (mem_we) nwe++;
      if (c <= 4) begin
        if (!mem_ce || mem_addr != base + 32'(c - 1)) seq_ok = 1'b0;
        if (!we && mem_we) seq_ok = 1'b0;
        if (we && mem_we && mem_din != wdata[8*(c-1) +: 8]) seq_ok = 1'b0;
      end else if (mem_ce) begin
        seq_ok = 1'b0;
      end
      dn = is_ls ? ls_done : if_done;
      if ((is_ls ? if_done : ls_done) == 1'b1) seq_ok = 1'b0;
      if (dn) begin
        seen  = 1'b1;
        lat   = c;
        rdata = is_ls ? ls_rdata : if_rdata;
        if (stall_req) seq_ok = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
      end else if (!stall_req) begin
        seq_ok = 1'b0;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        is_ls;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  bsel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;  // read word, or the ls_rdata value that a write must leave unchanged
    int          exp_lat;
    int          exp_nwe;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rd;
    int          lat, nwe;
    logic        ok;
    int          ls_at, if_at, ce_cnt, d1, d2;
    logic        both, stall_bad, ce7;
    logic [31:0] a8;
    logic        r_ls, r_we;
    logic [31:0] r_addr, r_wdata;
    logic [3:0]  r_bsel;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 4'b0000, 32'h0,        32'h44332211, 6, 0};
    vecs[1] = '{1'b1, 1'b1, 32'h202, 4'b0110, 32'hAABBCCDD, 32'h00000000, 5, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 4'b0000, 32'h0,        32'h00BBCC00, 6, 0};
    vecs[3] = '{1'b1, 1'b1, 32'h300, 4'b0000, 32'hFFFFFFFF, 32'h00BBCC00, 5, 0};
    vecs[4] = '{1'b1, 1'b0, 32'h302, 4'b0000, 32'h0,        32'h00000000, 6, 0};
    vecs[5] = '{1'b1, 1'b1, 32'h300, 4'b1111, 32'h12345678, 32'h00000000, 5, 4};
    vecs[6] = '{1'b0, 1'b0, 32'h301, 4'b0000, 32'h0,        32'h12345678, 6, 0};
    vecs[7] = '{1'b0, 1'b0, 32'h103, 4'b0000, 32'h0,        32'h44332211, 6, 0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ref_mem[256] = 8'h11; ref_mem[257] = 8'h22; ref_mem[258] = 8'h33; ref_mem[259] = 8'h44;

    // Reset held for three cycles with both requests high
    ram_init = 1'b1;
    rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    if_addr = 32'h0; ls_addr = 32'h0; ls_bsel = 4'h0; ls_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_done",  if_done,  1'b0);
    chk("rst_ls_done",  ls_done,  1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_mem_ce",   mem_ce,   1'b0);
    chk("rst_mem_we",   mem_we,   1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_din",  mem_din,  8'h0);
    chk("rst_stall",    stall_req, 1'b1);
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; ls_req = 1'b0; ram_init = 1'b0;
    @(posedge clk); #1;
    exp_if_rd = 32'h0;
    exp_ls_rd = 32'h0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].is_ls, vecs[i].we, vecs[i].addr, vecs[i].bsel, vecs[i].wdata,
             rd, lat, nwe, ok);
      if (vecs[i].we) model_write(vecs[i].addr, vecs[i].bsel, vecs[i].wdata);
      chk($sformatf("tbl%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("tbl%0d_nwe", i), nwe, vecs[i].exp_nwe);
      chk($sformatf("tbl%0d_seq", i), ok, 1'b1);
      if (vecs[i].we) begin
        chk($sformatf("tbl%0d_ls_rdata_hold", i), ls_rdata, vecs[i].exp_rdata);
      end else begin
        chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_rdata);
        if (vecs[i].is_ls) exp_ls_rd = vecs[i].exp_rdata;
        else               exp_if_rd = vecs[i].exp_rdata;
      end
    end

    // Simultaneous requests: LS first, then IF after one IDLE cycle
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h300; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
    ls_at = -1; if_at = -1; ce_cnt = 0; both = 1'b0; stall_bad = 1'b0; a8 = 32'h0;
    for (int c = 1; c <= 30 && if_at < 0; c++) begin
      @(posedge clk); #1;
      if (mem_ce) ce_cnt++;
      if (c == 8) a8 = mem_addr;
      if (ls_done && if_done) both = 1'b1;
      if (ls_done) begin
        ls_at = c;
        chk("sim_ls_rdata", ls_rdata, 32'h44332211);
        ls_req = 1'b0;
      end
      if (if_done) begin
        if_at = c;
        chk("sim_if_rdata", if_rdata, 32'h12345678);
        if_req = 1'b0;
      end else if (!stall_req) begin
        stall_bad = 1'b1;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    chk("sim_ls_done_cycle", ls_at, 6);
    chk("sim_if_done_cycle", if_at, 13);
    chk("sim_ce_cycles", ce_cnt, 8);
    chk("sim_if_first_addr", a8, 32'h300);
    chk("sim_no_double_done", both, 1'b0);
    chk("sim_stall_held", stall_bad, 1'b0);
    exp_ls_rd = 32'h44332211;
    exp_if_rd = 32'h12345678;
    @(posedge clk); #1;

    // Back-to-back IF reads with the request held and a new address
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    d1 = -1; d2 = -1; ce7 = 1'b1; a8 = 32'h0;
    for (int c = 1; c <= 30 && d2 < 0; c++) begin
      @(posedge clk); #1;
      if (c == 7) ce7 = mem_ce;
      if (c == 8) a8 = mem_addr;
      if (if_done) begin
        if (d1 < 0) begin
          d1 = c;
          chk("b2b_rdata1", if_rdata, 32'h00BBCC00);
          if_addr = 32'h100;
        end else begin
          d2 = c;
          chk("b2b_rdata2", if_rdata, 32'h44332211);
          if_req = 1'b0;
        end
      end
    end
    if_req = 1'b0;
    chk("b2b_done1_cycle", d1, 6);
    chk("b2b_done2_cycle", d2, 13);
    chk("b2b_idle_gap_ce", ce7, 1'b0);
    chk("b2b_second_addr", a8, 32'h100);
    exp_if_rd = 32'h44332211;
    @(posedge clk); #1;

    // Reset during the third read byte (RD k=2) abandons the transaction
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; if_req = 1'b0;
    @(posedge clk); #1;
    chk("midrst_if_done",  if_done,  1'b0);
    chk("midrst_if_rdata", if_rdata, 32'h0);
    chk("midrst_ls_rdata", ls_rdata, 32'h0);
    chk("midrst_mem_ce",   mem_ce,   1'b0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_late_done", if_done, 1'b0);
    exp_if_rd = 32'h0;
    exp_ls_rd = 32'h0;
    do_txn(1'b0, 1'b0, 32'h300, 4'h0, 32'h0, rd, lat, nwe, ok);
    chk("midrst_recover_lat", lat, 6);
    chk("midrst_recover_rdata", rd, model_read(32'h300));
    chk("midrst_recover_seq", ok, 1'b1);
    exp_if_rd = model_read(32'h300);

    // Randomized traffic against the reference memory
    for (int n = 0; n < 40; n++) begin
      r_ls    = 1'($urandom_range(0, 1));
      r_we    = r_ls & 1'($urandom_range(0, 1));
      r_addr  = 32'($urandom_range(0, 1023));
      r_bsel  = 4'($urandom_range(0, 15));
      r_wdata = $urandom;
      do_txn(r_ls, r_we, r_addr, r_bsel, r_wdata, rd, lat, nwe, ok);
      chk($sformatf("rnd%0d_seq", n), ok, 1'b1);
      if (r_we) begin
        model_write(r_addr, r_bsel, r_wdata);
        chk($sformatf("rnd%0d_wr_lat", n), lat, 5);
        chk($sformatf("rnd%0d_nwe", n), nwe, $countones(r_bsel));
      end else begin
        chk($sformatf("rnd%0d_rd_lat", n), lat, 6);
        chk($sformatf("rnd%0d_nwe", n), nwe, 0);
        chk($sformatf("rnd%0d_rdata", n), rd, model_read(r_addr));
        if (r_ls) exp_ls_rd = model_read(r_addr);
        else      exp_if_rd = model_read(r_addr);
      end
      chk($sformatf("rnd%0d_if_rdata_hold", n), if_rdata, exp_if_rd);
      chk($sformatf("rnd%0d_ls_rdata_hold", n), ls_rdata, exp_ls_rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
